// File: rtl/local_history_predictor.sv
// Local-history branch predictor with a direct-mapped BTB: combinational lookup, table updates on check.
// Resolution outputs (mispredicted/restart_pc/stats) are registered one cycle after check; there is no backpressure.
module local_history_predictor #(
    parameter int BHT_IDX  = 4,
    parameter int HIST_LEN = 2,
    parameter int CTR_W    = 2,
    parameter int BTB_IDX  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic [31:0] pc_curr,
    input  logic        check,
    input  logic [31:0] pc_curr_update,
    input  logic [31:0] pc_out_br_bus,
    input  logic        was_taken_not_taken,
    input  logic        was_jump,
    output logic [31:0] predicted_pc,
    output logic        pred_taken,
    output logic        mispredicted,
    output logic [31:0] restart_pc,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);
    localparam int BHT_N = 1 << BHT_IDX;
    localparam int CTR_N = 1 << HIST_LEN;
    localparam int BTB_N = 1 << BTB_IDX;
    localparam int TAG_W = 30 - BTB_IDX;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_MAX >> 1;
    localparam logic [CTR_W-1:0] CTR_ONE  = 1;

    logic [HIST_LEN-1:0] hist_q    [BHT_N];
    logic [CTR_W-1:0]    ctr_q     [BHT_N][CTR_N];
    logic                btb_vld_q [BTB_N];
    logic [TAG_W-1:0]    btb_tag_q [BTB_N];
    logic [31:0]         btb_tgt_q [BTB_N];

    logic        mispredicted_q, mispredicted_d;
    logic [31:0] restart_pc_q, restart_pc_d;
    logic [31:0] br_count_q, br_count_d;
    logic [31:0] mispred_count_q, mispred_count_d;

    // Fetch-side lookup
    logic [BHT_IDX-1:0]  rd_bi;
    logic [BTB_IDX-1:0]  rd_ti;
    logic [HIST_LEN-1:0] rd_hist;
    logic                rd_hit;
    logic                rd_pred;

    assign rd_bi   = pc_curr[BHT_IDX+1:2];
    assign rd_ti   = pc_curr[BTB_IDX+1:2];
    assign rd_hist = hist_q[rd_bi];
    assign rd_hit  = btb_vld_q[rd_ti] && (btb_tag_q[rd_ti] == pc_curr[31:BTB_IDX+2]);
    assign rd_pred = ctr_q[rd_bi][rd_hist][CTR_W-1] & rd_hit;

    assign pred_taken   = read & rd_pred;
    assign predicted_pc = !read  ? 32'd0 :
                          rd_pred ? btb_tgt_q[rd_ti] : pc_curr + 32'd4;

    // Resolution-side lookup, always against pre-edge table contents
    logic [BHT_IDX-1:0]  ck_bi;
    logic [BTB_IDX-1:0]  ck_ti;
    logic [HIST_LEN-1:0] ck_hist;
    logic [CTR_W-1:0]    ck_ctr;
    logic                ck_hit;
    logic                ck_pred;
    logic                ck_mis;
    logic [HIST_LEN:0]   hist_shift;

    assign ck_bi      = pc_curr_update[BHT_IDX+1:2];
    assign ck_ti      = pc_curr_update[BTB_IDX+1:2];
    assign ck_hist    = hist_q[ck_bi];
    assign ck_ctr     = ctr_q[ck_bi][ck_hist];
    assign ck_hit     = btb_vld_q[ck_ti] && (btb_tag_q[ck_ti] == pc_curr_update[31:BTB_IDX+2]);
    assign ck_pred    = ck_ctr[CTR_W-1] & ck_hit;
    assign ck_mis     = (ck_pred != was_taken_not_taken) ||
                        (ck_pred && was_taken_not_taken && (btb_tgt_q[ck_ti] != pc_out_br_bus));
    assign hist_shift = {ck_hist, was_taken_not_taken};

    logic [HIST_LEN-1:0] ctr_wr_idx;
    logic [CTR_W-1:0]    ctr_wr_val;
    logic [HIST_LEN-1:0] hist_wr_val;

    // Jumps force the entry to its strongest taken pattern so the next fetch redirects.
    always_comb begin
        ctr_wr_idx  = ck_hist;
        ctr_wr_val  = ck_ctr;
        hist_wr_val = hist_shift[HIST_LEN-1:0];
        if (was_jump) begin
            ctr_wr_idx  = '1;
            ctr_wr_val  = CTR_MAX;
            hist_wr_val = '1;
        end else if (was_taken_not_taken) begin
            if (ck_ctr != CTR_MAX) ctr_wr_val = ck_ctr + CTR_ONE;
        end else begin
            if (ck_ctr != '0) ctr_wr_val = ck_ctr - CTR_ONE;
        end
    end

    assign mispredicted_d  = check & ck_mis;
    assign restart_pc_d    = !check ? 32'd0 :
                             was_taken_not_taken ? pc_out_br_bus : pc_curr_update + 32'd4;
    assign br_count_d      = (check && (br_count_q != '1)) ? br_count_q + 32'd1 : br_count_q;
    assign mispred_count_d = (check && ck_mis && (mispred_count_q != '1)) ?
                             mispred_count_q + 32'd1 : mispred_count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < BHT_N; i++) begin
                hist_q[i] <= '0;
                for (int j = 0; j < CTR_N; j++) ctr_q[i][j] <= CTR_INIT;
            end
            for (int i = 0; i < BTB_N; i++) begin
                btb_vld_q[i] <= 1'b0;
                btb_tag_q[i] <= '0;
                btb_tgt_q[i] <= '0;
            end
            mispredicted_q  <= 1'b0;
            restart_pc_q    <= '0;
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            mispredicted_q  <= mispredicted_d;
            restart_pc_q    <= restart_pc_d;
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
            if (check) begin
                hist_q[ck_bi]             <= hist_wr_val;
                ctr_q[ck_bi][ctr_wr_idx]  <= ctr_wr_val;
                if (was_taken_not_taken || was_jump) begin
                    btb_vld_q[ck_ti] <= 1'b1;
                    btb_tag_q[ck_ti] <= pc_curr_update[31:BTB_IDX+2];
                    btb_tgt_q[ck_ti] <= pc_out_br_bus;
                end
            end
        end
    end

    assign mispredicted  = mispredicted_q;
    assign restart_pc    = restart_pc_q;
    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_local_history_predictor.sv
// Scoreboarded bench: stimulus pushes model expectations, a negedge monitor pops and compares.
module tb_local_history_predictor;
    localparam int BHT_IDX  = 4;
    localparam int HIST_LEN = 2;
    localparam int CTR_W    = 2;
    localparam int BTB_IDX  = 4;
    localparam int BHT_N    = 1 << BHT_IDX;
    localparam int HN       = 1 << HIST_LEN;
    localparam int BTB_N    = 1 << BTB_IDX;
    localparam int CMAX     = (1 << CTR_W) - 1;
    localparam int CHALF    = 1 << (CTR_W - 1);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        read = 1'b0;
    logic [31:0] pc_curr = '0;
    logic        check = 1'b0;
    logic [31:0] pc_curr_update = '0;
    logic [31:0] pc_out_br_bus = '0;
    logic        was_taken_not_taken = 1'b0;
    logic        was_jump = 1'b0;
    logic [31:0] predicted_pc;
    logic        pred_taken;
    logic        mispredicted;
    logic [31:0] restart_pc;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    local_history_predictor #(
        .BHT_IDX(BHT_IDX), .HIST_LEN(HIST_LEN), .CTR_W(CTR_W), .BTB_IDX(BTB_IDX)
    ) dut (
        .clk(clk), .rst(rst), .read(read), .pc_curr(pc_curr), .check(check),
        .pc_curr_update(pc_curr_update), .pc_out_br_bus(pc_out_br_bus),
        .was_taken_not_taken(was_taken_not_taken), .was_jump(was_jump),
        .predicted_pc(predicted_pc), .pred_taken(pred_taken), .mispredicted(mispredicted),
        .restart_pc(restart_pc), .br_count(br_count), .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic t; logic [31:0] pc; } pred_t;
    typedef struct packed { logic mis; logic [31:0] rpc; logic [31:0] br; logic [31:0] mc; } resp_t;

    pred_t pred_q[$];
    resp_t resp_q[$];
    int    n_total = 0;
    int    n_pass  = 0;

    // Reference state: plain integers, indices and tags by division.
    int          m_hist [BHT_N];
    int          m_ctr  [BHT_N][HN];
    bit          m_bv   [BTB_N];
    logic [31:0] m_tag  [BTB_N];
    logic [31:0] m_tgt  [BTB_N];
    longint      m_br;
    longint      m_mc;

    function automatic void model_reset();
        for (int i = 0; i < BHT_N; i++) begin
            m_hist[i] = 0;
            for (int j = 0; j < HN; j++) m_ctr[i][j] = CHALF - 1;
        end
        for (int i = 0; i < BTB_N; i++) begin
            m_bv[i]  = 1'b0;
            m_tag[i] = '0;
            m_tgt[i] = '0;
        end
        m_br = 0;
        m_mc = 0;
    endfunction

    function automatic void model_lookup(input logic [31:0] pc, output logic t, output logic [31:0] npc);
        int bi  = int'((pc / 4) % BHT_N);
        int ti  = int'((pc / 4) % BTB_N);
        bit hit = m_bv[ti] && (m_tag[ti] == pc / (4 * BTB_N));
        t   = hit && (m_ctr[bi][m_hist[bi]] >= CHALF);
        npc = t ? m_tgt[ti] : pc + 32'd4;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
    endtask

    // One clock of stimulus; called just after a rising edge.
    task automatic step(input bit rn, input bit rd, input logic [31:0] pc, input bit ck,
                        input logic [31:0] upd, input logic [31:0] tgt, input bit tk, input bit jp);
        pred_t       p;
        resp_t       r;
        logic        ct;
        logic [31:0] cnpc;
        bit          mis;
        int          bi, ti, h;
        rst = rn; read = rd; pc_curr = pc; check = ck;
        pc_curr_update = upd; pc_out_br_bus = tgt; was_taken_not_taken = tk; was_jump = jp;
        if (rd) begin
            model_lookup(pc, p.t, p.pc);
            pred_q.push_back(p);
        end
        if (!rn) begin
            model_reset();
            r = '0;
        end else if (ck) begin
            model_lookup(upd, ct, cnpc);
            bi  = int'((upd / 4) % BHT_N);
            ti  = int'((upd / 4) % BTB_N);
            h   = m_hist[bi];
            mis = (ct != tk) || (ct && tk && (m_tgt[ti] != tgt));
            if (jp) begin
                m_hist[bi]        = HN - 1;
                m_ctr[bi][HN - 1] = CMAX;
            end else begin
                if (tk) m_ctr[bi][h] = (m_ctr[bi][h] < CMAX) ? m_ctr[bi][h] + 1 : CMAX;
                else    m_ctr[bi][h] = (m_ctr[bi][h] > 0) ? m_ctr[bi][h] - 1 : 0;
                m_hist[bi] = (h * 2 + int'(tk)) % HN;
            end
            if (tk || jp) begin
                m_bv[ti]  = 1'b1;
                m_tag[ti] = upd / (4 * BTB_N);
                m_tgt[ti] = tgt;
            end
            if (m_br < 64'hFFFF_FFFF) m_br++;
            if (mis && m_mc < 64'hFFFF_FFFF) m_mc++;
            r.mis = mis;
            r.rpc = tk ? tgt : upd + 32'd4;
            r.br  = m_br[31:0];
            r.mc  = m_mc[31:0];
        end else begin
            r.mis = 1'b0;
            r.rpc = '0;
            r.br  = m_br[31:0];
            r.mc  = m_mc[31:0];
        end
        @(posedge clk);
        #1;
        resp_q.push_back(r);
    endtask

    function automatic logic [31:0] rand_pc();
        return 32'h1000 | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2);
    endfunction

    // Monitor: read is the valid for the combinational prediction; a queued
    // response becomes due at the first falling edge after its clock edge.
    initial begin
        pred_t p;
        resp_t r;
        forever begin
            @(negedge clk);
            if (read) begin
                if (pred_q.size() == 0) begin
                    chk("pred_underflow", 32'd1, 32'd0);
                end else begin
                    p = pred_q.pop_front();
                    chk("pred_taken", {31'd0, pred_taken}, {31'd0, p.t});
                    chk("predicted_pc", predicted_pc, p.pc);
                end
            end else begin
                chk("idle_pred_taken", {31'd0, pred_taken}, 32'd0);
                chk("idle_predicted_pc", predicted_pc, 32'd0);
            end
            if (resp_q.size() != 0) begin
                r = resp_q.pop_front();
                chk("mispredicted", {31'd0, mispredicted}, {31'd0, r.mis});
                chk("restart_pc", restart_pc, r.rpc);
                chk("br_count", br_count, r.br);
                chk("mispred_count", mispred_count, r.mc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // Cold read, then first taken resolution
        step(1, 1, 32'h100, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 32'h100, 32'h80, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // Train from reset: three mispredicts, then a correct prediction
        step(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 32'h100, 32'h80, 1, 0);
        step(1, 1, 32'h100, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 32'h100, 32'h80, 1, 0);
        // Alias miss, then read alongside a not-taken check of the same PC
        step(1, 1, 32'h140, 0, 0, 0, 0, 0);
        step(1, 1, 32'h100, 1, 32'h100, 32'h80, 0, 0);
        step(1, 1, 32'h100, 0, 0, 0, 0, 0);
        // Jump with direction bit low still trains toward its target
        step(1, 0, 0, 1, 32'h200, 32'h300, 0, 1);
        step(1, 1, 32'h200, 0, 0, 0, 0, 0);
        // Back-to-back checks to one index, then reset coinciding with a check
        step(1, 1, 32'h100, 1, 32'h100, 32'h80, 1, 0);
        step(1, 1, 32'h100, 1, 32'h100, 32'h80, 1, 0);
        step(0, 0, 0, 1, 32'h100, 32'h80, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 32'h100, 0, 0, 0, 0, 0);
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 63) != 0, $urandom_range(0, 1) != 0, rand_pc(),
                 $urandom_range(0, 2) != 0, rand_pc(), 32'h8000 | ($urandom_range(0, 3) << 4),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
        end
        rst = 1'b1; read = 1'b0; check = 1'b0; was_jump = 1'b0; was_taken_not_taken = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("queues_drained", pred_q.size() + resp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/local_history_predictor.md
LOCAL_HISTORY_PREDICTOR -- requirements
Module: local_history_predictor

Interface
REQ-001 SHALL have parameter BHT_IDX, default 4, meaning the BHT index width; the BHT holds 2^BHT_IDX entries indexed by pc[BHT_IDX+1:2].
REQ-002 SHALL have parameter HIST_LEN, default 2, meaning the per-entry local history length in bits; each entry holds 2^HIST_LEN counters.
REQ-003 SHALL have parameter CTR_W, default 2, meaning the saturating counter width.
REQ-004 SHALL have parameter BTB_IDX, default 4, meaning the BTB index width; tag = pc[31:BTB_IDX+2], TAG_W = 30-BTB_IDX.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: the reset, synchronous and active-low (rst=0 resets on the rising clk edge).
REQ-007 SHALL have port read, input, 1 bit: prediction request for pc_curr.
REQ-008 SHALL have port pc_curr, input, 32 bits: fetch PC.
REQ-009 SHALL have port check, input, 1 bit: a resolved branch/jump is presented this cycle.
REQ-010 SHALL have port pc_curr_update, input, 32 bits: PC of the resolved instruction.
REQ-011 SHALL have port pc_out_br_bus, input, 32 bits: actual target when taken.
REQ-012 SHALL have port was_taken_not_taken, input, 1 bit: actual direction (1 = taken).
REQ-013 SHALL have port was_jump, input, 1 bit: resolved instruction is an unconditional jump.
REQ-014 SHALL have port predicted_pc, output, 32 bits: combinational prediction.
REQ-015 SHALL have port pred_taken, output, 1 bit: combinational predicted direction.
REQ-016 SHALL have port mispredicted, output, 1 bit: registered one-cycle pulse.
REQ-017 SHALL have port restart_pc, output, 32 bits: registered redirect PC.
REQ-018 SHALL have ports br_count and mispred_count, outputs, 32 bits each: registered statistics.

Function
REQ-019 SHALL, when read=1, set pred_taken = counter[hist].MSB & btb_hit for pc_curr and predicted_pc = pred_taken ? btb_target : pc_curr+4; when read=0, both outputs SHALL be 0.
REQ-020 SHALL define btb_hit as valid & (stored tag == pc tag) at the BTB index.
REQ-021 SHALL, on check=1, compute chk_pred from the pre-edge state of pc_curr_update using the rule of REQ-019.
REQ-022 SHALL, on check=1, assert the mispredict condition when chk_pred != was_taken_not_taken, or when both are 1 and btb_target != pc_out_br_bus.
REQ-023 SHALL, on the edge after check, set mispredicted to the REQ-022 result and restart_pc = was_taken_not_taken ? pc_out_br_bus : pc_curr_update+4; without check, both SHALL be 0 on the next cycle.
REQ-024 SHALL, on a conditional check (was_jump=0), increment counter[old hist] saturating at 2^CTR_W-1 if taken, else decrement saturating at 0, and set history = {old_hist[HIST_LEN-2:0], taken}.
REQ-025 SHALL, on a jump check, set history to all ones and counter[all ones] to 2^CTR_W-1, regardless of was_taken_not_taken.
REQ-026 SHALL, on a check that is taken or a jump, write the BTB entry with valid=1, tag and pc_out_br_bus; a not-taken check SHALL leave the BTB unchanged.
REQ-027 SHALL make all table writes visible starting the cycle after the check; a same-cycle read of the same index returns pre-update values.
REQ-028 SHALL, for back-to-back checks to the same index, compute the second check from state already updated by the first.
REQ-029 SHALL, on each check, increment br_count, and increment mispred_count when the mispredict condition holds; both SHALL saturate at 0xFFFFFFFF.
REQ-030 SHALL overwrite a BTB entry on an aliasing PC (different tag, same index), with no replacement policy.

Reset
REQ-031 SHALL, while rst=0 at an edge, clear all histories to 0, set all counters to 2^(CTR_W-1)-1 (weakly not-taken), clear all BTB valid bits, and clear mispredicted, restart_pc, br_count and mispred_count to 0.
REQ-032 SHALL discard a check coincident with reset, with no table or counter update.

Verification (defaults)
REQ-033 SHALL verify: reset, then read pc_curr=0x100 -> pred_taken=0, predicted_pc=0x104.
REQ-034 SHALL verify: check 0x100 taken, target 0x80 -> next cycle mispredicted=1, restart_pc=0x80, br_count=1, mispred_count=1.
REQ-035 SHALL verify: three taken checks to 0x100 (target 0x80) -> all three mispredict; read 0x100 then gives predicted_pc=0x80; a fourth taken check gives mispredicted=0.
REQ-036 SHALL verify: jump check 0x200 to 0x300 -> next-cycle read 0x200 gives predicted_pc=0x300, pred_taken=1.
REQ-037 SHALL verify: after REQ-035 training, read 0x140 (same indices, different tag) -> predicted_pc=0x144; read 0x100 in the same cycle as a not-taken check of 0x100 -> predicted_pc=0x80.
REQ-038 SHALL verify: rst=0 asserted with check=1 mid-sequence -> next cycle all outputs are 0 and read 0x100 gives predicted_pc=0x104.
